// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states and RV32I load/store funct3 codes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width encodings; the unsigned forms exist for loads alone.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension and store byte-merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = mem_word[8*int'(addr_lo) +: 8];
    assign sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = mem_word;
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        store_word = mem_word;
        case (funct3)
            F3_B: store_word[8*int'(addr_lo) +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-memory responder with fixed wait states and a valid/ready response handshake.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic        do_access;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_funct3;

    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_funct3;
    logic [AW-1:0] acc_idx;
    logic        out_of_range;
    logic        misalign;
    logic        acc_err;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // With zero wait states the access happens on the acceptance edge, straight from the request bus.
    always_comb begin
        if (state == IDLE) begin
            acc_write  = req_write;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_write  = cap_write;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
            acc_funct3 = cap_funct3;
        end
    end

    assign acc_idx      = acc_addr[AW+1:2];
    assign out_of_range = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign mem_word     = mem[acc_idx];

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (acc_funct3)
            F3_H, F3_HU: misalign = acc_addr[0];
            F3_W:        misalign = |acc_addr[1:0];
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign acc_err = out_of_range || !f3_legal(acc_write, acc_funct3) || misalign;

    dmem_lane_align u_lane_align (
        .addr_lo    (acc_addr[1:0]),
        .funct3     (acc_funct3),
        .mem_word   (mem_word),
        .wdata      (acc_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        next_state = state;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                        do_access  = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = RESP;
                    do_access  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_funct3 <= 3'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == WAIT)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;

            if (req_valid && req_ready) begin
                cap_write  <= req_write;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_funct3 <= req_funct3;
            end

            if (do_access) begin
                rsp_rdata <= (acc_err || acc_write) ? 32'd0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_n, and rst_n only gates commits.
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_write && !acc_err)
            mem[acc_idx] <= store_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table with a response scoreboard plus stall/reset sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int WC    = 1;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic [31:0] er, input logic ee);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.f3 = f; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(WC + 1));
    endtask

    task automatic do_txn(input string name, input vec_t v);
        int   n;
        int   lat;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        drive_req(v.write, v.addr, v.wdata, v.f3);
        @(posedge clk);
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        #1 req_valid = 1'b0;
        wait_rsp(name, lat);
        if (rsp_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({name, "_rdata"}, rsp_rdata, e.rdata);
            check({name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, "_idle_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        exp_t e;

        // Reset state, sampled while reset is held.
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h10, 32'h00000000, F3_W, 32'h0, 0));
        vecs.push_back(mk(1, 32'h13, 32'h12345680, F3_B, 32'h0, 0));
        vecs.push_back(mk(0, 32'h13, 32'h0, F3_B, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 32'h13, 32'h0, F3_BU, 32'h00000080, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0, F3_W, 32'h80000000, 0));
        vecs.push_back(mk(1, 32'h14, 32'h11223344, F3_W, 32'h0, 0));
        vecs.push_back(mk(1, 32'h16, 32'hAAAA8001, F3_H, 32'h0, 0));
        vecs.push_back(mk(0, 32'h14, 32'h0, F3_W, 32'h80013344, 0));
        vecs.push_back(mk(0, 32'h16, 32'h0, F3_H, 32'hFFFF8001, 0));
        vecs.push_back(mk(0, 32'h14, 32'h0, F3_HU, 32'h00003344, 0));
        vecs.push_back(mk(0, 32'h15, 32'h0, F3_B, 32'h00000033, 0));
        // Alignment-sensitive accesses.
        vecs.push_back(mk(0, 32'h11, 32'h0, F3_H, 32'h00000000, MIS));
        vecs.push_back(mk(1, 32'h20, 32'hC0DE9ABC, F3_W, 32'h0, 0));
        vecs.push_back(mk(0, 32'h21, 32'h0, F3_H, MIS ? 32'h0 : 32'hFFFF9ABC, MIS));
        vecs.push_back(mk(0, 32'h23, 32'h0, F3_W, MIS ? 32'h0 : 32'hC0DE9ABC, MIS));
        vecs.push_back(mk(1, 32'h24, 32'h00000000, F3_W, 32'h0, 0));
        vecs.push_back(mk(1, 32'h25, 32'h00001234, F3_H, 32'h0, MIS));
        vecs.push_back(mk(0, 32'h24, 32'h0, F3_W, MIS ? 32'h0 : 32'h00001234, 0));
        // Out of range and illegal encodings leave storage untouched.
        vecs.push_back(mk(0, 32'(DEPTH * 4), 32'h0, F3_W, 32'h0, 1));
        vecs.push_back(mk(1, 32'(DEPTH * 4), 32'h12345678, F3_W, 32'h0, 1));
        vecs.push_back(mk(0, 32'hFFFF_FFFC, 32'h0, F3_W, 32'h0, 1));
        vecs.push_back(mk(1, 32'h10, 32'hFFFFFFFF, 3'b011, 32'h0, 1));
        vecs.push_back(mk(1, 32'h10, 32'hFFFFFFFF, F3_BU, 32'h0, 1));
        vecs.push_back(mk(1, 32'h10, 32'hFFFFFFFF, F3_HU, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10, 32'h0, 3'b110, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10, 32'h0, 3'b111, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10, 32'h0, F3_W, 32'h80000000, 0));

        foreach (vecs[i])
            do_txn($sformatf("vec%0d", i), vecs[i]);

        // Response back-pressure: outputs hold, no new request is taken.
        @(negedge clk);
        drive_req(0, 32'h10, 32'h0, F3_W);
        @(posedge clk);
        sb_q.push_back('{rdata: 32'h80000000, err: 1'b0});
        #1 req_valid = 1'b0;
        wait_rsp("stall", lat);
        e = sb_q.pop_front();
        drive_req(1, 32'h10, 32'h00000BAD, F3_W);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d_rdata", k), rsp_rdata, e.rdata);
            check($sformatf("stall%0d_err", k), {31'd0, rsp_err}, {31'd0, e.err});
            check($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);
        do_txn("after_stall", mk(0, 32'h10, 32'h0, F3_W, 32'h80000000, 0));

        // Reset during the wait state discards the pending store.
        @(negedge clk);
        drive_req(1, 32'h10, 32'h55555555, F3_W);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst_in_wait", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn("after_rst", mk(0, 32'h10, 32'h0, F3_W, 32'h80000000, 0));

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
